multimode_timekeeper: RTL and testbench
=======================================

# multimode_timekeeper

- Parametrised three-mode timekeeper: 24-hour clock, stopwatch with lap hold, and countdown with alarm.
- All three units run concurrently from one shared prescaler. A button-driven mode FSM selects which unit drives six packed BCD digits.
- Sits between the board button/switch synchronisers and the seven-segment decoder bank; the decoders render digit value 4'hF as blank.

## Interface

- CLK_HZ, 50_000_000 — input clock frequency; must be a multiple of 100.
- ALARM_SEC, 10 — number of seconds alarm stays asserted after countdown expiry.
- clk  in  1  system clock.
- reset  in  1  reset. One clock; reset is synchronous and active-high.
- mode_btn  in  1  level, synchronised; each rising edge advances the mode.
- start_btn  in  1  rising edge toggles run/stop of the displayed unit.
- lap_btn  in  1  rising edge toggles lap hold (stopwatch mode only).
- clear_btn  in  1  rising edge clears the displayed unit.
- set_load  in  1  single-cycle write strobe.
- set_sel  in  3  digit index 0..5 written by set_load.
- set_val  in  4  BCD value written by set_load.
- digits  out  24  digit k at [4k+3:4k]; digit 0 is rightmost.
- blank  out  6  per-digit blank flag; a blanked digit also outputs 4'hF.
- mode  out  2  0 = CLOCK, 1 = STOPWATCH, 2 = COUNTDOWN.
- running  out  1  run state of the displayed unit; always 1 in CLOCK.
- alarm  out  1  countdown expiry alarm.

## Operation

- **Prescaler.** Counts 0..DIV-1, with DIV = CLK_HZ/100. centi_tick is high in the cycle where the count equals DIV-1. A centi counter 0..99 advances on each centi_tick. sec_tick = centi_tick AND centi == 99.
- **Edge detect.** All four buttons are edge-detected internally: a register holds each previous level, and an action fires in the cycle where the level is 1 and the previous level was 0.
- **Mode FSM.** CLOCK → STOPWATCH → COUNTDOWN → CLOCK on each mode_btn edge. Any other button edge in the same cycle applies to the mode before the transition.
- **Clock.**
  - HH:MM:SS, shown as d5d4 : d3d2 : d1d0.
  - Advances on sec_tick; 23:59:59 wraps to 00:00:00.
  - set_load in CLOCK writes digit set_sel. The write is ignored if the value is illegal for that position: tens of seconds/minutes > 5, units > 9, hour tens > 2, hours ≥ 24 after the write.
  - start_btn and clear_btn have no effect in CLOCK.
- **Stopwatch.**
  - MM:SS:hh, shown as d5d4 : d3d2 : d1d0.
  - Advances on centi_tick while running; 59:59.99 wraps to 00:00.00.
  - start toggles running.
  - lap, only while running, toggles lap hold. Hold freezes the displayed value while counting continues; releasing hold shows the live value.
  - clear stops the stopwatch, zeroes it, and releases hold.
  - Stopping clears hold.
- **Countdown.**
  - MM:SS in d3..d0; d5 and d4 are blanked.
  - Holds a preset register and a current value.
  - set_load with set_sel 0..3 writes the preset digit. If stopped, it also writes the current value. The same legality rules as the clock apply (tens ≤ 5, units ≤ 9); writes with set_sel 4..5 are ignored.
  - Decrements on sec_tick while running.
  - Reaching 00:00 stops the countdown, asserts alarm, and loads alarm_cnt = ALARM_SEC.
  - start at 00:00 is ignored.
  - clear stops the countdown and reloads current from preset.
- **Alarm.** Deasserts when alarm_cnt reaches 0; alarm_cnt decrements on each sec_tick. Alarm is also cleared by any button edge, and that edge is consumed: it performs no other action.
- **Set/tick collision.** If set_load and a tick for the same unit coincide, the write wins and that unit's tick is dropped for that cycle.
- **Reset values.**
  - mode = 0, all counters and presets = 0, prescaler = 0.
  - running = 1 (CLOCK is displayed), all units stopped, hold = 0, alarm = 0.
  - digits = 24'h000000, blank = 0.
- **Reset mid-operation.** Restores all state, including the prescaler phase.

## Timing

- Unit state updates on the clock edge ending the tick or action cycle.
- digits, blank, mode, running and alarm are combinational from registered state: zero added latency, so a change is visible in the cycle after the causing event.
- First centi_tick occurs in cycle DIV-1 after reset deasserts. The first sec_tick follows 100·DIV cycles after reset.
- Button action latency: one cycle from the rising level to the state change.
- The prescaler is never reset by mode changes, start, clear or set writes.

## Test plan

- **Clock rollover.** CLK_HZ = 1000; write 23:59:58 via six set_load writes; wait 2000 cycles → digits = 24'h000000.
- **Stopwatch with lap hold.** start; after 1230 cycles, lap → display frozen at 00:01.23. After a further 500 cycles, lap → display shows 00:01.73. Then clear → 00:00.00 and running = 0.
- **Countdown expiry and alarm timeout.** Preset 00:03, start → after 3000 cycles current = 00:00, running = 0, alarm = 1. ALARM_SEC = 2: alarm drops 2000 cycles later.
- **Alarm clear consumes edge.** During alarm, a start_btn edge → alarm = 0 and the countdown does not restart.
- **Mode and illegal writes.** Three mode edges cycle mode 1, 2, 0. start_btn and mode_btn in the same cycle while in STOPWATCH → stopwatch runs and mode = 2. set_val = 7 to set_sel = 1 in CLOCK → ignored.
- **Reset mid-run.** Assert reset mid-run with alarm active → every output takes its reset value on the next cycle.

Source files
------------

// File: rtl/multimode_timekeeper.sv
// Three-mode timekeeper: a 24-hour clock, a lap-hold stopwatch and an alarmed countdown
// share one 10 ms prescaler. A button-driven mode FSM picks the unit that drives the display.
module multimode_timekeeper #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int ALARM_SEC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_btn,
    input  logic        start_btn,
    input  logic        lap_btn,
    input  logic        clear_btn,
    input  logic        set_load,
    input  logic [2:0]  set_sel,
    input  logic [3:0]  set_val,
    output logic [23:0] digits,
    output logic [5:0]  blank,
    output logic [1:0]  mode,
    output logic        running,
    output logic        alarm
);
    localparam int DIV = CLK_HZ / 100;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
    localparam int AW  = (ALARM_SEC > 0) ? $clog2(ALARM_SEC + 1) : 1;
    // Per-digit roll-over values, digit 0 in the low nibble.
    localparam logic [23:0] SW_LIM   = 24'h595999;
    localparam logic [15:0] MMSS_LIM = 16'h5959;

    typedef enum logic [1:0] {
        ST_CLOCK = 2'd0,
        ST_SW    = 2'd1,
        ST_CD    = 2'd2
    } state_t;

    genvar gi;

    logic [PW-1:0] presc_reg;
    logic [6:0]    centi_reg;
    logic          centi_tick;
    logic          sec_tick;

    assign centi_tick = (presc_reg == DIV_LAST);
    assign sec_tick   = centi_tick && (centi_reg == 7'd99);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg <= '0;
            centi_reg <= '0;
        end else if (centi_tick) begin
            presc_reg <= '0;
            centi_reg <= (centi_reg == 7'd99) ? 7'd0 : centi_reg + 7'd1;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    logic [3:0] btn_level;
    logic [3:0] btn_prev_reg;
    logic [3:0] btn_rise;
    logic [3:0] btn_act;
    logic       alarm_reg;
    logic       alarm_consume;
    logic       act_mode, act_start, act_lap, act_clear;

    assign btn_level = {clear_btn, lap_btn, start_btn, mode_btn};
    // While the alarm sounds, any button edge only silences it.
    assign alarm_consume = alarm_reg & (|btn_rise);

    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_btn
            assign btn_rise[gi] = btn_level[gi] & ~btn_prev_reg[gi];
            assign btn_act[gi]  = btn_rise[gi] & ~alarm_consume;
        end
    endgenerate

    assign act_mode  = btn_act[0];
    assign act_start = btn_act[1];
    assign act_lap   = btn_act[2];
    assign act_clear = btn_act[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev_reg <= '0;
        end else begin
            btn_prev_reg <= btn_level;
        end
    end

    state_t state_reg, state_next;
    logic   is_clock, is_sw, is_cd;

    assign is_clock = (state_reg == ST_CLOCK);
    assign is_sw    = (state_reg == ST_SW);
    assign is_cd    = (state_reg == ST_CD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_CLOCK;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (act_mode) begin
            case (state_reg)
                ST_CLOCK: state_next = ST_SW;
                ST_SW:    state_next = ST_CD;
                default:  state_next = ST_CLOCK;
            endcase
        end
    end

    logic [3:0] set_lim;
    logic       set_val_ok;

    always_comb begin
        case (set_sel)
            3'd0, 3'd2, 3'd4: set_lim = 4'd9;
            3'd1, 3'd3:       set_lim = 4'd5;
            3'd5:             set_lim = 4'd2;
            default:          set_lim = 4'd0;
        endcase
    end
    assign set_val_ok = (set_sel <= 3'd5) && (set_val <= set_lim);

    logic [5:0][3:0] clk_reg, clk_inc, clk_next;
    logic [3:0]      clk_h1_wr, clk_h0_wr;
    logic            clk_carry;
    logic            clk_wr_ok;
    logic            clk_tick;

    // Hour legality is judged on the pair as it would look after the write.
    assign clk_h1_wr = (set_sel == 3'd5) ? set_val : clk_reg[5];
    assign clk_h0_wr = (set_sel == 3'd4) ? set_val : clk_reg[4];
    assign clk_wr_ok = set_load && is_clock && set_val_ok &&
                       !((clk_h1_wr == 4'd2) && (clk_h0_wr > 4'd3));
    assign clk_tick  = sec_tick && !clk_wr_ok;

    always_comb begin
        clk_inc   = clk_reg;
        clk_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (clk_carry) begin
                if (clk_reg[i] == MMSS_LIM[4*i +: 4]) begin
                    clk_inc[i] = 4'd0;
                end else begin
                    clk_inc[i] = clk_reg[i] + 4'd1;
                    clk_carry  = 1'b0;
                end
            end
        end
        if (clk_carry) begin
            if ((clk_reg[5] == 4'd2) && (clk_reg[4] == 4'd3)) begin
                clk_inc[5] = 4'd0;
                clk_inc[4] = 4'd0;
            end else if (clk_reg[4] == 4'd9) begin
                clk_inc[5] = clk_reg[5] + 4'd1;
                clk_inc[4] = 4'd0;
            end else begin
                clk_inc[4] = clk_reg[4] + 4'd1;
            end
        end
    end

    generate
        for (gi = 0; gi < 6; gi = gi + 1) begin : g_clk_next
            assign clk_next[gi] = (clk_wr_ok && (set_sel == 3'(gi))) ? set_val :
                                  (clk_tick ? clk_inc[gi] : clk_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_reg <= '0;
        end else begin
            clk_reg <= clk_next;
        end
    end

    logic [5:0][3:0] sw_reg, sw_snap_reg, sw_inc;
    logic            sw_run_reg;
    logic            sw_hold_reg;
    logic            sw_carry;

    always_comb begin
        sw_inc   = sw_reg;
        sw_carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (sw_carry) begin
                if (sw_reg[i] == SW_LIM[4*i +: 4]) begin
                    sw_inc[i] = 4'd0;
                end else begin
                    sw_inc[i] = sw_reg[i] + 4'd1;
                    sw_carry  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_reg      <= '0;
            sw_snap_reg <= '0;
            sw_run_reg  <= 1'b0;
            sw_hold_reg <= 1'b0;
        end else if (is_sw && act_clear) begin
            sw_reg      <= '0;
            sw_run_reg  <= 1'b0;
            sw_hold_reg <= 1'b0;
        end else begin
            if (centi_tick && sw_run_reg) begin
                sw_reg <= sw_inc;
            end
            if (is_sw && act_start) begin
                sw_run_reg <= !sw_run_reg;
                if (sw_run_reg) begin
                    sw_hold_reg <= 1'b0;
                end
            end else if (is_sw && act_lap && sw_run_reg) begin
                sw_hold_reg <= !sw_hold_reg;
                if (!sw_hold_reg) begin
                    sw_snap_reg <= sw_reg;
                end
            end
        end
    end

    logic [3:0][3:0] cd_pre_reg, cd_cur_reg, cd_dec, cd_pre_wr, cd_cur_wr;
    logic            cd_run_reg;
    logic            cd_borrow;
    logic            cd_wr_ok;
    logic            cd_clear;
    logic            cd_tick;
    logic            cd_expire;

    assign cd_wr_ok  = set_load && is_cd && set_val_ok && (set_sel <= 3'd3);
    assign cd_clear  = is_cd && act_clear;
    assign cd_tick   = sec_tick && cd_run_reg && !cd_wr_ok && !cd_clear;
    assign cd_expire = cd_tick && (cd_dec == '0);

    always_comb begin
        cd_dec    = cd_cur_reg;
        cd_borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cd_borrow) begin
                if (cd_cur_reg[i] == 4'd0) begin
                    cd_dec[i] = MMSS_LIM[4*i +: 4];
                end else begin
                    cd_dec[i] = cd_cur_reg[i] - 4'd1;
                    cd_borrow = 1'b0;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_cd_wr
            assign cd_pre_wr[gi] = (set_sel == 3'(gi)) ? set_val : cd_pre_reg[gi];
            assign cd_cur_wr[gi] = (set_sel == 3'(gi)) ? set_val : cd_cur_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            cd_pre_reg <= '0;
            cd_cur_reg <= '0;
            cd_run_reg <= 1'b0;
        end else begin
            if (cd_clear) begin
                cd_run_reg <= 1'b0;
                cd_cur_reg <= cd_pre_reg;
            end else if (is_cd && act_start) begin
                if (cd_run_reg) begin
                    cd_run_reg <= 1'b0;
                end else if (cd_cur_reg != '0) begin
                    cd_run_reg <= 1'b1;
                end
            end
            if (cd_tick) begin
                cd_cur_reg <= cd_dec;
                if (cd_expire) begin
                    cd_run_reg <= 1'b0;
                end
            end
            if (cd_wr_ok) begin
                cd_pre_reg <= cd_pre_wr;
                if (!cd_run_reg) begin
                    cd_cur_reg <= cd_cur_wr;
                end
            end
        end
    end

    logic [AW-1:0] alarm_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_reg     <= 1'b0;
            alarm_cnt_reg <= '0;
        end else if (cd_expire) begin
            alarm_reg     <= 1'b1;
            alarm_cnt_reg <= AW'(ALARM_SEC);
        end else if (alarm_consume) begin
            alarm_reg     <= 1'b0;
            alarm_cnt_reg <= '0;
        end else if (sec_tick && alarm_reg) begin
            if (alarm_cnt_reg <= AW'(1)) begin
                alarm_reg     <= 1'b0;
                alarm_cnt_reg <= '0;
            end else begin
                alarm_cnt_reg <= alarm_cnt_reg - AW'(1);
            end
        end
    end

    logic [5:0][3:0] disp_raw;

    always_comb begin
        mode     = state_reg;
        disp_raw = clk_reg;
        blank    = 6'b000000;
        running  = 1'b1;
        case (state_reg)
            ST_SW: begin
                disp_raw = sw_hold_reg ? sw_snap_reg : sw_reg;
                running  = sw_run_reg;
            end
            ST_CD: begin
                disp_raw = {8'h00, cd_cur_reg};
                blank    = 6'b110000;
                running  = cd_run_reg;
            end
            default: ;
        endcase
    end

    generate
        for (gi = 0; gi < 6; gi = gi + 1) begin : g_digits
            assign digits[4*gi +: 4] = blank[gi] ? 4'hF : disp_raw[gi];
        end
    endgenerate

    assign alarm = alarm_reg;

endmodule

// File: tb/tb_multimode_timekeeper.sv
// Directed bench for multimode_timekeeper at CLK_HZ=1000 (10-cycle centi, 1000-cycle second),
// with expected values queued at stimulus time and popped at each sample point.
module tb_multimode_timekeeper;
    logic        clk = 1'b0;
    logic        reset;
    logic        mode_btn, start_btn, lap_btn, clear_btn;
    logic        set_load;
    logic [2:0]  set_sel;
    logic [3:0]  set_val;
    logic [23:0] digits;
    logic [5:0]  blank;
    logic [1:0]  mode;
    logic        running;
    logic        alarm;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    multimode_timekeeper #(.CLK_HZ(1000), .ALARM_SEC(2)) dut (
        .clk(clk), .reset(reset),
        .mode_btn(mode_btn), .start_btn(start_btn), .lap_btn(lap_btn), .clear_btn(clear_btn),
        .set_load(set_load), .set_sel(set_sel), .set_val(set_val),
        .digits(digits), .blank(blank), .mode(mode), .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Edges since reset released; the prescaler phase is a pure function of this.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic check_val(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic goto(input int m);
        while (cyc < m) @(negedge clk);
    endtask

    // mask = {clear, lap, start, mode}; one-cycle high pulse
    task automatic press(input logic [3:0] mask);
        {clear_btn, lap_btn, start_btn, mode_btn} = mask;
        @(negedge clk);
        {clear_btn, lap_btn, start_btn, mode_btn} = 4'b0000;
    endtask

    task automatic write(input logic [2:0] sel, input logic [3:0] val);
        set_load = 1'b1;
        set_sel  = sel;
        set_val  = val;
        @(negedge clk);
        set_load = 1'b0;
    endtask

    task automatic check_all_reset(input string pfx);
        expect_val({pfx, "_digits"}, 32'h000000);
        expect_val({pfx, "_blank"}, 32'h0);
        expect_val({pfx, "_mode"}, 32'h0);
        expect_val({pfx, "_running"}, 32'h1);
        expect_val({pfx, "_alarm"}, 32'h0);
        check_val(32'(digits));
        check_val(32'(blank));
        check_val(32'(mode));
        check_val(32'(running));
        check_val(32'(alarm));
    endtask

    initial begin
        reset = 1'b1;
        {clear_btn, lap_btn, start_btn, mode_btn} = 4'b0000;
        set_load = 1'b0;
        set_sel  = 3'd0;
        set_val  = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all_reset("reset");
        $display("step reset_state cyc=%0d digits=%h", cyc, digits);

        // Clock: load 23:59:58, reject illegal writes, roll over at the second tick.
        goto(1);
        write(3'd5, 4'd2); write(3'd4, 4'd3); write(3'd3, 4'd5);
        write(3'd2, 4'd9); write(3'd1, 4'd5); write(3'd0, 4'd8);
        expect_val("clk_loaded", 32'h235958);
        goto(500); check_val(32'(digits));
        $display("step clock_load cyc=%0d digits=%h", cyc, digits);
        goto(600);
        write(3'd1, 4'd7); write(3'd4, 4'd5); write(3'd5, 4'd3); write(3'd6, 4'd1);
        expect_val("clk_illegal_ignored", 32'h235958);
        goto(700); check_val(32'(digits));
        expect_val("clk_first_sec", 32'h235959);
        goto(1500); check_val(32'(digits));
        expect_val("clk_rollover", 32'h000000);
        expect_val("clk_running", 32'h1);
        goto(2005); check_val(32'(digits)); check_val(32'(running));
        $display("step clock_rollover cyc=%0d digits=%h", cyc, digits);

        // Stopwatch with lap hold.
        goto(2100); press(4'b0001);
        expect_val("sw_mode", 32'h1); expect_val("sw_idle_running", 32'h0);
        expect_val("sw_idle_digits", 32'h0);
        goto(2102); check_val(32'(mode)); check_val(32'(running)); check_val(32'(digits));
        goto(3000); press(4'b0010);
        expect_val("sw_started", 32'h1);
        goto(3002); check_val(32'(running));
        goto(4235); press(4'b0100);
        expect_val("sw_lap_capture", 32'h000123);
        goto(4237); check_val(32'(digits));
        expect_val("sw_lap_frozen", 32'h000123);
        goto(4500); check_val(32'(digits));
        $display("step sw_lap_hold cyc=%0d digits=%h", cyc, digits);
        goto(4735); press(4'b0100);
        expect_val("sw_lap_release", 32'h000173); expect_val("sw_still_running", 32'h1);
        goto(4737); check_val(32'(digits)); check_val(32'(running));
        goto(4800); press(4'b1000);
        expect_val("sw_clear_digits", 32'h0); expect_val("sw_clear_running", 32'h0);
        goto(4802); check_val(32'(digits)); check_val(32'(running));
        $display("step sw_clear cyc=%0d digits=%h running=%0d", cyc, digits, running);

        // Countdown: preset, illegal writes, expiry and alarm timeout.
        goto(4900); press(4'b0001);
        expect_val("cd_mode", 32'h2); expect_val("cd_blank", 32'h30);
        expect_val("cd_digits_init", 32'hFF0000); expect_val("cd_running_init", 32'h0);
        goto(4902); check_val(32'(mode)); check_val(32'(blank));
        check_val(32'(digits)); check_val(32'(running));
        goto(4910); write(3'd0, 4'd3);
        expect_val("cd_preset", 32'hFF0003);
        goto(4912); check_val(32'(digits));
        goto(4920); write(3'd1, 4'd6); write(3'd4, 4'd1); write(3'd0, 4'hA);
        expect_val("cd_illegal_ignored", 32'hFF0003);
        goto(4925); check_val(32'(digits));
        goto(5100); press(4'b0010);
        expect_val("cd_one_sec", 32'hFF0002); expect_val("cd_running", 32'h1);
        goto(6500); check_val(32'(digits)); check_val(32'(running));
        expect_val("cd_expired", 32'hFF0000); expect_val("cd_stopped", 32'h0);
        expect_val("cd_alarm_on", 32'h1);
        goto(8001); check_val(32'(digits)); check_val(32'(running)); check_val(32'(alarm));
        $display("step cd_expiry cyc=%0d digits=%h alarm=%0d", cyc, digits, alarm);
        expect_val("alarm_still_on", 32'h1);
        goto(9990); check_val(32'(alarm));
        expect_val("alarm_timeout", 32'h0);
        goto(10001); check_val(32'(alarm));
        $display("step alarm_timeout cyc=%0d alarm=%0d", cyc, alarm);

        // Alarm cleared by a start edge, which must not restart the countdown.
        goto(10100); press(4'b1000);
        expect_val("cd_clear_reload", 32'hFF0003);
        goto(10102); check_val(32'(digits));
        goto(10200); press(4'b0010);
        expect_val("cd_alarm_again", 32'h1);
        goto(13001); check_val(32'(alarm));
        goto(13100); press(4'b0010);
        expect_val("alarm_consumed", 32'h0); expect_val("consume_no_restart", 32'h0);
        expect_val("consume_digits", 32'hFF0000);
        goto(13102); check_val(32'(alarm)); check_val(32'(running)); check_val(32'(digits));
        goto(13200); press(4'b0010);
        expect_val("start_at_zero_ignored", 32'h0);
        goto(13202); check_val(32'(running));
        $display("step alarm_consume cyc=%0d alarm=%0d running=%0d", cyc, alarm, running);

        // Mode cycling, clock kept counting in the background, simultaneous start+mode.
        goto(13300); press(4'b0001);
        expect_val("back_to_clock_mode", 32'h0); expect_val("clock_running", 32'h1);
        expect_val("clock_background", 32'h000011);
        goto(13302); check_val(32'(mode)); check_val(32'(running)); check_val(32'(digits));
        goto(13400); press(4'b0001);
        goto(13500); press(4'b0011);
        expect_val("start_mode_same_cycle_mode", 32'h2);
        goto(13502); check_val(32'(mode));
        goto(13600); press(4'b0001);
        goto(13700); press(4'b0001);
        expect_val("sw_started_before_mode", 32'h1); expect_val("sw_bg_count", 32'h000020);
        goto(13702); check_val(32'(running)); check_val(32'(digits));
        $display("step start_with_mode cyc=%0d mode=%0d digits=%h", cyc, mode, digits);

        // Reset mid-run with the alarm active, then prescaler phase restart.
        goto(13800); press(4'b0001);
        goto(13900); press(4'b1000);
        goto(14000); press(4'b0010);
        expect_val("pre_reset_alarm", 32'h1);
        goto(17002); check_val(32'(alarm));
        goto(17500);
        reset = 1'b1;
        @(negedge clk);
        check_all_reset("midrun_reset");
        reset = 1'b0;
        expect_val("post_reset_before_sec", 32'h000000);
        goto(999); check_val(32'(digits));
        expect_val("post_reset_first_sec", 32'h000001);
        goto(1000); check_val(32'(digits));
        $display("step midrun_reset cyc=%0d digits=%h", cyc, digits);

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover remaining=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
